spi_flash_loader: RTL and testbench

- Parametrised loader that copies a contiguous image from SPI NOR flash into an on-chip 16-bit-wide RAM through a generic write port.
- Supersedes the fixed 32 KiB, fixed-address, power-on-only loader.
- Adds configurable flash offset, image size, SPI clock divider and optional wake (0xAB) sequence.
- Adds restartable loads via start/busy/done handshake and a defined byte order.
- Sits between the SPI flash pins and the ROM SPRAM; the cartridge bus front end gates output on done.

---
 rtl/spi_flash_loader.sv | 207 ++++++++++++++++++++
 tb/tb_spi_flash_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_loader.sv
// spi_flash_loader
// Copies a contiguous image from SPI NOR flash into a 16-bit-wide on-chip RAM.
// It issues a READ (0x03) command with a 24-bit address and then streams the
// data. Before that it can optionally send a release-power-down (0xAB) command
// and wait. The first flash byte of each word lands in ram_wdata[7:0].
//
// State table:
//   state       | meaning
//   S_IDLE      | waiting for start (or the automatic start after reset)
//   S_WAKE      | shifting out 0xAB
//   S_WAKE_WAIT | SSN high, counting WAKE_DELAY cycles
//   S_CMD       | shifting out {0x03, FLASH_ADDR}
//   S_READ      | shifting in 16-bit words and strobing them into RAM
//   S_DONE      | image loaded; done held until the next load starts
//
// Ports:
//   clk, rst_n                : system clock, asynchronous active-low reset
//   start                     : load request, honoured in IDLE or DONE
//   busy, done                : load in progress / load complete (sticky)
//   ram_we, ram_addr, ram_wdata : RAM write port, one strobe per word
//   spi_sck, spi_ssn, spi_mosi, spi_miso : SPI mode 0 master pins
module spi_flash_loader #(
   parameter logic [23:0] FLASH_ADDR = 24'h100000,
   parameter int          WORDS      = 16384,
   parameter int          ADDR_W     = 14,
   parameter int          CLK_DIV    = 8,
   parameter bit          WAKE_EN    = 1'b0,
   parameter int          WAKE_DELAY = 4096,
   parameter bit          AUTO_START = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              spi_sck,
   output logic              spi_ssn,
   output logic              spi_mosi,
   input  logic              spi_miso
);

   localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int WAIT_W = (WAKE_DELAY > 1) ? $clog2(WAKE_DELAY) : 1;
   localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]  DIV_H    = DIV_W'(CLK_DIV / 2);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WAKE_DELAY - 1);
   localparam logic [31:0]       READ_CMD = {8'h03, FLASH_ADDR};
   localparam logic [31:0]       WAKE_CMD = {8'hAB, 24'h000000};

   typedef enum logic [2:0] {
      S_IDLE, S_WAKE, S_WAKE_WAIT, S_CMD, S_READ, S_DONE
   } state_t;

   state_t            state;
   logic              auto_pend;
   logic              last_word;
   logic [DIV_W-1:0]  div_cnt;
   logic [4:0]        bit_cnt;
   logic [ADDR_W-1:0] word_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [31:0]       tx_sr;
   logic [14:0]       rx_sr;
   logic              shifting;
   logic              bit_end;

   // div_cnt counts down through one SCK period. The bit ends on the cycle
   // where it reaches zero, and that edge both drives SCK low and samples MISO.
   assign shifting = (state == S_WAKE || state == S_CMD || state == S_READ) && !last_word;
   assign bit_end  = (div_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         spi_sck   <= 1'b0;
         spi_ssn   <= 1'b1;
         spi_mosi  <= 1'b0;
         auto_pend <= AUTO_START;
         last_word <= 1'b0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
         word_cnt  <= '0;
         wait_cnt  <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
      end else begin
         ram_we    <= 1'b0;
         auto_pend <= 1'b0;

         if (shifting) begin
            if (bit_end) begin
               spi_sck <= 1'b0;
               div_cnt <= DIV_MAX;
            end else begin
               div_cnt <= div_cnt - DIV_W'(1);
               if (div_cnt == DIV_H) spi_sck <= 1'b1;
            end
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (start || auto_pend) begin
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  spi_ssn  <= 1'b0;
                  spi_sck  <= 1'b0;
                  ram_addr <= '0;
                  div_cnt  <= DIV_MAX;
                  word_cnt <= ADDR_W'(WORDS - 1);
                  if (WAKE_EN) begin
                     state    <= S_WAKE;
                     spi_mosi <= WAKE_CMD[31];
                     tx_sr    <= {WAKE_CMD[30:0], 1'b0};
                     bit_cnt  <= 5'd7;
                  end else begin
                     state    <= S_CMD;
                     spi_mosi <= READ_CMD[31];
                     tx_sr    <= {READ_CMD[30:0], 1'b0};
                     bit_cnt  <= 5'd31;
                  end
               end
            end

            S_WAKE: begin
               if (bit_end) begin
                  if (bit_cnt == '0) begin
                     state    <= S_WAKE_WAIT;
                     spi_ssn  <= 1'b1;
                     spi_mosi <= 1'b0;
                     wait_cnt <= WAIT_MAX;
                  end else begin
                     bit_cnt  <= bit_cnt - 5'd1;
                     spi_mosi <= tx_sr[31];
                     tx_sr    <= {tx_sr[30:0], 1'b0};
                  end
               end
            end

            S_WAKE_WAIT: begin
               if (wait_cnt == '0) begin
                  state    <= S_CMD;
                  spi_ssn  <= 1'b0;
                  spi_mosi <= READ_CMD[31];
                  tx_sr    <= {READ_CMD[30:0], 1'b0};
                  bit_cnt  <= 5'd31;
                  div_cnt  <= DIV_MAX;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end

            S_CMD: begin
               if (bit_end) begin
                  if (bit_cnt == '0) begin
                     state    <= S_READ;
                     bit_cnt  <= 5'd15;
                     spi_mosi <= 1'b0;
                  end else begin
                     bit_cnt  <= bit_cnt - 5'd1;
                     spi_mosi <= tx_sr[31];
                     tx_sr    <= {tx_sr[30:0], 1'b0};
                  end
               end
            end

            S_READ: begin
               if (last_word) begin
                  state     <= S_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  last_word <= 1'b0;
               end else begin
                  // Address advances on the cycle after each strobe.
                  if (ram_we) ram_addr <= ram_addr + ADDR_W'(1);
                  if (bit_end) begin
                     rx_sr <= {rx_sr[13:0], spi_miso};
                     if (bit_cnt == '0) begin
                        // Serial order is byte0 then byte1; swap so byte0 is the low byte.
                        ram_we    <= 1'b1;
                        ram_wdata <= {rx_sr[6:0], spi_miso, rx_sr[14:7]};
                        bit_cnt   <= 5'd15;
                        if (word_cnt == '0) begin
                           last_word <= 1'b1;
                           spi_ssn   <= 1'b1;
                        end else begin
                           word_cnt <= word_cnt - ADDR_W'(1);
                        end
                     end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                     end
                  end
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_flash_loader.sv
// Testbench for spi_flash_loader: five instances in different configurations,
// each attached to a small SPI flash model that serves bytes 0x11,0x22,...
// Instances:
//   0: WORDS=4 CLK_DIV=2 auto start      (baseline, mid-load reset)
//   1: WORDS=4 CLK_DIV=8 auto start      (SCK duty, long latency)
//   2: WORDS=4 CLK_DIV=2 wake, delay 10
//   3: WORDS=4 CLK_DIV=2 manual start
//   4: WORDS=1 ADDR_W=1 CLK_DIV=2
module tb_spi_flash_loader;

   logic        clk;
   logic        rst_all;
   logic        rst_x;
   logic        start3;
   logic        busy [5];
   logic        done [5];
   logic        we   [5];
   logic [13:0] addr_w [5];
   logic        addr4;
   logic [15:0] wdata [5];
   logic        sck  [5];
   logic        ssn  [5];
   logic        mosi [5];
   wire         miso_w [5];

   int checks   = 0;
   int failures = 0;
   int e        = 0;
   int bad;
   int base0;
   logic [15:0] exp_word [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign addr_w[4] = {13'b0, addr4};

   spi_flash_loader #(.WORDS(4), .ADDR_W(14), .CLK_DIV(2), .WAKE_EN(1'b0), .AUTO_START(1'b1)) u0 (
      .clk(clk), .rst_n(rst_all & rst_x), .start(1'b0), .busy(busy[0]), .done(done[0]),
      .ram_we(we[0]), .ram_addr(addr_w[0]), .ram_wdata(wdata[0]),
      .spi_sck(sck[0]), .spi_ssn(ssn[0]), .spi_mosi(mosi[0]), .spi_miso(miso_w[0]));

   spi_flash_loader #(.WORDS(4), .ADDR_W(14), .CLK_DIV(8), .WAKE_EN(1'b0), .AUTO_START(1'b1)) u1 (
      .clk(clk), .rst_n(rst_all), .start(1'b0), .busy(busy[1]), .done(done[1]),
      .ram_we(we[1]), .ram_addr(addr_w[1]), .ram_wdata(wdata[1]),
      .spi_sck(sck[1]), .spi_ssn(ssn[1]), .spi_mosi(mosi[1]), .spi_miso(miso_w[1]));

   spi_flash_loader #(.WORDS(4), .ADDR_W(14), .CLK_DIV(2), .WAKE_EN(1'b1), .WAKE_DELAY(10),
                      .AUTO_START(1'b1)) u2 (
      .clk(clk), .rst_n(rst_all), .start(1'b0), .busy(busy[2]), .done(done[2]),
      .ram_we(we[2]), .ram_addr(addr_w[2]), .ram_wdata(wdata[2]),
      .spi_sck(sck[2]), .spi_ssn(ssn[2]), .spi_mosi(mosi[2]), .spi_miso(miso_w[2]));

   spi_flash_loader #(.WORDS(4), .ADDR_W(14), .CLK_DIV(2), .WAKE_EN(1'b0), .AUTO_START(1'b0)) u3 (
      .clk(clk), .rst_n(rst_all), .start(start3), .busy(busy[3]), .done(done[3]),
      .ram_we(we[3]), .ram_addr(addr_w[3]), .ram_wdata(wdata[3]),
      .spi_sck(sck[3]), .spi_ssn(ssn[3]), .spi_mosi(mosi[3]), .spi_miso(miso_w[3]));

   spi_flash_loader #(.WORDS(1), .ADDR_W(1), .CLK_DIV(2), .WAKE_EN(1'b0), .AUTO_START(1'b1)) u4 (
      .clk(clk), .rst_n(rst_all), .start(1'b0), .busy(busy[4]), .done(done[4]),
      .ram_we(we[4]), .ram_addr(addr4), .ram_wdata(wdata[4]),
      .spi_sck(sck[4]), .spi_ssn(ssn[4]), .spi_mosi(mosi[4]), .spi_miso(miso_w[4]));

   // Data stream bit n: byte n/8 holds (n/8+1)*0x11, sent MSB first.
   function automatic logic flash_bit(input int n);
      logic [7:0] b;
      b = 8'((n / 8 + 1) * 17);
      return b[7 - (n % 8)];
   endfunction

   for (genvar i = 0; i < 5; i++) begin : g_fl
      int          pcnt = 0;
      logic [31:0] sr = '0;
      int          last_len = 0;
      logic [31:0] last_sr = '0;
      logic        miso_q = 1'b0;
      int          wcount = 0;
      int          max_addr = 0;
      logic [13:0] la [64];
      logic [15:0] ld [64];

      assign miso_w[i] = miso_q;

      // Mode 0 flash: MOSI taken on SCK rise; the bit count restarts on SSN fall.
      always @(posedge sck[i] or negedge ssn[i]) begin
         if (sck[i]) begin
            sr   = {sr[30:0], mosi[i]};
            pcnt = pcnt + 1;
         end else begin
            pcnt = 0;
         end
      end

      // Data shifts out on SCK fall once the 32 command bits are in.
      always @(negedge sck[i]) begin
         if (pcnt >= 32) miso_q = flash_bit(pcnt - 32);
      end

      always @(posedge ssn[i]) begin
         last_len = pcnt;
         last_sr  = sr;
      end

      always @(posedge clk) begin
         if (we[i]) begin
            if (wcount < 64) begin
               la[wcount] = addr_w[i];
               ld[wcount] = wdata[i];
            end
            if (int'(addr_w[i]) > max_addr) max_addr = int'(addr_w[i]);
            wcount = wcount + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      e++;
   endtask

   task automatic go_to(input int k);
      while (e < k) tick();
   endtask

   initial begin
      exp_word[0] = 16'h2211;
      exp_word[1] = 16'h4433;
      exp_word[2] = 16'h6655;
      exp_word[3] = 16'h8877;
      rst_all = 1'b0;
      rst_x   = 1'b1;
      start3  = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy",  32'(busy[0]), 0);
      chk("rst_done",  32'(done[0]), 0);
      chk("rst_we",    32'(we[0]), 0);
      chk("rst_addr",  32'(addr_w[0]), 0);
      chk("rst_wdata", 32'(wdata[0]), 0);
      chk("rst_sck",   32'(sck[0]), 0);
      chk("rst_ssn",   32'(ssn[0]), 1);
      chk("rst_mosi",  32'(mosi[0]), 0);

      // Phase 1: all instances from one reset release; edge 0 is the first edge after it.
      @(negedge clk);
      rst_all = 1'b1;
      e = -1;

      go_to(0);
      chk("u0_busy_e0", 32'(busy[0]), 1);
      chk("u0_ssn_e0",  32'(ssn[0]), 0);
      chk("u0_mosi_e0", 32'(mosi[0]), 0);
      chk("u2_mosi_e0", 32'(mosi[2]), 1);
      chk("u3_busy_e0", 32'(busy[3]), 0);

      go_to(16);
      chk("u2_ssn_wake_end", 32'(ssn[2]), 1);
      go_to(17);
      chk("u2_wake_len",  32'(g_fl[2].last_len), 8);
      chk("u2_wake_byte", 32'(g_fl[2].last_sr[7:0]), 32'hAB);
      go_to(25);
      chk("u2_ssn_wait_last", 32'(ssn[2]), 1);
      go_to(26);
      chk("u2_ssn_cmd_start", 32'(ssn[2]), 0);
      chk("u2_mosi_cmd_start", 32'(mosi[2]), 0);

      go_to(49);
      chk("u3_busy_e49", 32'(busy[3]), 0);
      start3 = 1'b1;
      go_to(50);
      start3 = 1'b0;
      chk("u3_busy_e50", 32'(busy[3]), 1);

      go_to(64);
      chk("u0_cmd_bits", g_fl[0].sr, 32'h03100000);

      go_to(96);
      chk("u4_we_e96",    32'(we[4]), 1);
      chk("u4_ssn_e96",   32'(ssn[4]), 1);
      chk("u4_wdata_e96", 32'(wdata[4]), 32'h2211);
      go_to(97);
      chk("u4_done_e97", 32'(done[4]), 1);
      chk("u4_wcount",   32'(g_fl[4].wcount), 1);
      chk("u4_log_addr", 32'(g_fl[4].la[0]), 0);
      chk("u4_log_data", 32'(g_fl[4].ld[0]), 32'h2211);

      go_to(99);
      start3 = 1'b1;
      go_to(100);
      start3 = 1'b0;

      go_to(191);
      chk("u0_we_e191",   32'(we[0]), 0);
      chk("u0_done_e191", 32'(done[0]), 0);
      go_to(192);
      chk("u0_we_e192",    32'(we[0]), 1);
      chk("u0_ssn_e192",   32'(ssn[0]), 1);
      chk("u0_addr_e192",  32'(addr_w[0]), 3);
      chk("u0_done_e192",  32'(done[0]), 0);
      go_to(193);
      chk("u0_done_e193", 32'(done[0]), 1);
      chk("u0_busy_e193", 32'(busy[0]), 0);
      chk("u0_we_e193",   32'(we[0]), 0);
      chk("u0_wcount",    32'(g_fl[0].wcount), 4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("u0_log_addr%0d", k), 32'(g_fl[0].la[k]), 32'(k));
         chk($sformatf("u0_log_data%0d", k), 32'(g_fl[0].ld[k]), 32'(exp_word[k]));
      end

      go_to(217);
      chk("u2_done_e217", 32'(done[2]), 0);
      go_to(218);
      chk("u2_we_e218", 32'(we[2]), 1);
      go_to(219);
      chk("u2_done_e219", 32'(done[2]), 1);
      chk("u2_wcount",    32'(g_fl[2].wcount), 4);
      chk("u2_log_data3", 32'(g_fl[2].ld[3]), 32'h8877);

      go_to(242);
      chk("u3_done_e242", 32'(done[3]), 0);
      go_to(243);
      chk("u3_done_e243", 32'(done[3]), 1);
      chk("u3_wcount1",   32'(g_fl[3].wcount), 4);

      go_to(259);
      start3 = 1'b1;
      go_to(260);
      start3 = 1'b0;
      chk("u3_done_drop", 32'(done[3]), 0);
      chk("u3_busy_re",   32'(busy[3]), 1);
      chk("u3_addr_re",   32'(addr_w[3]), 0);

      go_to(453);
      chk("u3_done_e453", 32'(done[3]), 1);
      chk("u3_wcount2",   32'(g_fl[3].wcount), 8);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("u3_log2_addr%0d", k), 32'(g_fl[3].la[4 + k]), 32'(k));
         chk($sformatf("u3_log2_data%0d", k), 32'(g_fl[3].ld[4 + k]), 32'(exp_word[k]));
      end

      go_to(768);
      chk("u1_we_e768",   32'(we[1]), 1);
      chk("u1_done_e768", 32'(done[1]), 0);
      go_to(769);
      chk("u1_done_e769", 32'(done[1]), 1);
      chk("u4_max_addr",  32'(g_fl[4].max_addr), 0);
      chk("u4_wcount_end", 32'(g_fl[4].wcount), 1);

      // Phase 2: SCK duty on instance 1, then a mid-READ reset of instance 0.
      @(negedge clk);
      rst_all = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_all = 1'b1;
      e = -1;
      base0 = g_fl[0].wcount;

      bad = 0;
      for (int k = 1; k <= 40; k++) begin
         go_to(k);
         if (sck[1] !== ((k % 8) >= 4)) bad++;
      end
      chk("u1_sck_duty_errs", 32'(bad), 0);

      go_to(100);
      rst_x = 1'b0;
      #1;
      chk("u0_abort_ssn",  32'(ssn[0]), 1);
      chk("u0_abort_busy", 32'(busy[0]), 0);
      chk("u0_abort_we",   32'(we[0]), 0);
      chk("u0_abort_sck",  32'(sck[0]), 0);
      #1;
      rst_x = 1'b1;

      // Edge 101 is the first edge after release: the automatic reload starts there.
      go_to(101);
      chk("u0_restart_busy", 32'(busy[0]), 1);
      chk("u0_restart_addr", 32'(addr_w[0]), 0);
      go_to(101 + 192);
      chk("u0_restart_we",   32'(we[0]), 1);
      chk("u0_restart_addr3", 32'(addr_w[0]), 3);
      go_to(101 + 193);
      chk("u0_restart_done", 32'(done[0]), 1);
      chk("u0_restart_wcount", 32'(g_fl[0].wcount - base0), 5);
      chk("u0_partial_addr", 32'(g_fl[0].la[base0]), 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("u0_re_addr%0d", k), 32'(g_fl[0].la[base0 + 1 + k]), 32'(k));
         chk($sformatf("u0_re_data%0d", k), 32'(g_fl[0].ld[base0 + 1 + k]), 32'(exp_word[k]));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
